// File: rtl/itc_sync_lock_controller.sv
// rtl/itc_sync_lock_controller.sv - SOF sync generator lock sequencer with shadow registers
// Applies shadow settings on flush, then supervises sof_locked with timeout and retries.
module itc_sync_lock_controller #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_W      = 24,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  reg_addr,
    input  logic        reg_write,
    input  logic [15:0] reg_writedata,
    input  logic        reg_read,
    output logic [15:0] reg_readdata,
    input  logic        sof,
    input  logic        sof_locked,
    output logic        clear_enable,
    output logic        output_enable,
    output logic [13:0] sof_sample,
    output logic [12:0] sof_line,
    output logic [1:0]  sof_subsample,
    output logic [13:0] divider_value,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TMR_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]           RETRY_MAX = 4'(MAX_RETRIES);

    state_t               state, state_nxt;
    logic [3:0]           retry, retry_nxt;
    logic [TIMEOUT_W-1:0] tmr;
    logic [15:0]          frame_count;
    logic [13:0]          shd_sample, shd_divider;
    logic [12:0]          shd_line;
    logic [1:0]           shd_subsample;
    logic                 irq_en, irq_lost, irq_fault;
    logic                 lost_set, fault_set;
    logic                 ctrl_wr, ctrl_go, ctrl_stop, irq_wr;
    logic [15:0]          rd_mux;
    logic                 unused_wdata;

    assign unused_wdata = ^reg_writedata[15:14];
    assign ctrl_wr   = reg_write && (reg_addr == 3'd0);
    assign ctrl_go   = ctrl_wr && reg_writedata[0];
    assign ctrl_stop = ctrl_wr && reg_writedata[1];
    assign irq_wr    = reg_write && (reg_addr == 3'd7);

    // STOP outranks GO, and both outrank lock/timeout handling.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry;
        lost_set  = 1'b0;
        fault_set = 1'b0;
        if (ctrl_stop) begin
            state_nxt = S_IDLE;
        end else if (ctrl_go) begin
            state_nxt = S_FLUSH;
            retry_nxt = 4'd0;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_FLUSH: state_nxt = S_ARM;
                S_ARM: begin
                    if (sof_locked) begin
                        state_nxt = S_RUN;
                    end else if (tmr == TMR_LAST) begin
                        if (retry < RETRY_MAX) begin
                            retry_nxt = retry + 4'd1;
                            state_nxt = S_FLUSH;
                        end else begin
                            state_nxt = S_FAULT;
                            fault_set = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!sof_locked) begin
                        state_nxt = S_FLUSH;
                        retry_nxt = 4'd0;
                        lost_set  = 1'b1;
                    end
                end
                S_FAULT: state_nxt = S_FAULT;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = 16'd0;
        case (reg_addr)
            3'd0: rd_mux = {13'd0, irq_en, 2'b00};
            3'd1: rd_mux = {8'd0, retry, (state == S_RUN), state};
            3'd2: rd_mux = {2'd0, shd_sample};
            3'd3: rd_mux = {3'd0, shd_line};
            3'd4: rd_mux = {14'd0, shd_subsample};
            3'd5: rd_mux = {2'd0, shd_divider};
            3'd6: rd_mux = frame_count;
            3'd7: rd_mux = {14'd0, irq_fault, irq_lost};
            default: rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            retry         <= 4'd0;
            tmr           <= '0;
            frame_count   <= 16'd0;
            shd_sample    <= 14'd0;
            shd_line      <= 13'd0;
            shd_subsample <= 2'd0;
            shd_divider   <= 14'd0;
            sof_sample    <= 14'd0;
            sof_line      <= 13'd0;
            sof_subsample <= 2'd0;
            divider_value <= 14'd0;
            irq_en        <= 1'b0;
            irq_lost      <= 1'b0;
            irq_fault     <= 1'b0;
            irq           <= 1'b0;
            clear_enable  <= 1'b0;
            output_enable <= 1'b0;
            reg_readdata  <= 16'd0;
        end else begin
            state         <= state_nxt;
            retry         <= retry_nxt;
            clear_enable  <= (state_nxt == S_FLUSH);
            output_enable <= (state_nxt == S_ARM) || (state_nxt == S_RUN);

            // Active values only ever change on the edge that enters FLUSH.
            if (state_nxt == S_FLUSH) begin
                sof_sample    <= shd_sample;
                sof_line      <= shd_line;
                sof_subsample <= shd_subsample;
                divider_value <= shd_divider;
            end

            if (reg_write) begin
                case (reg_addr)
                    3'd2: shd_sample    <= reg_writedata[13:0];
                    3'd3: shd_line      <= reg_writedata[12:0];
                    3'd4: shd_subsample <= reg_writedata[1:0];
                    3'd5: shd_divider   <= reg_writedata[13:0];
                    default: ;
                endcase
            end

            if (state == S_FLUSH)
                tmr <= '0;
            else if (state == S_ARM)
                tmr <= tmr + 1'b1;

            if (state == S_FLUSH)
                frame_count <= 16'd0;
            else if ((state == S_RUN) && sof)
                frame_count <= frame_count + 16'd1;

            if (ctrl_wr)
                irq_en <= reg_writedata[2];
            // A set event in the same cycle as a clear leaves the bit set.
            irq_lost  <= lost_set  | (irq_lost  & ~(irq_wr & reg_writedata[0]));
            irq_fault <= fault_set | (irq_fault & ~(irq_wr & reg_writedata[1]));
            irq       <= irq_en & (irq_lost | irq_fault);

            if (reg_read)
                reg_readdata <= rd_mux;
        end
    end

endmodule
